// File: rtl/sweep_acq_top.sv
// Sweep acquisition controller: steps the DAC0 code from StartDAC0 to EndDAC0.
// At each code it loads the slow control, acquires MaxPackageNumber packages,
// then writes one record per code into the USB data FIFO.
// Optional feature macro: SWEEP_ACQ_HEADER_EN. When it is defined, each record
// opens with HEADER_WORD (3 words); by default a record is 2 words (DAC, count).
// reset_n is the legacy reset of this codebase: asynchronous and active-high.
module sweep_acq_top #(
  parameter logic [15:0] HEADER_WORD = 16'h5A5A,
  parameter int unsigned DAC_WIDTH   = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 SweepStart,
  output logic                 SingleACQStart,
  output logic                 ForceMicrorocAcqReset,
  output logic                 ACQDone,
  input  logic                 DataTransmitDone,
  input  logic [DAC_WIDTH-1:0] StartDAC0,
  input  logic [DAC_WIDTH-1:0] EndDAC0,
  input  logic [15:0]          MaxPackageNumber,
  input  logic [15:0]          ParallelData,
  input  logic                 ParallelData_en,
  output logic [DAC_WIDTH-1:0] OutDAC0,
  output logic                 LoadSCParameter,
  input  logic                 MicrorocConfigDone,
  output logic [15:0]          SweepACQData,
  output logic                 SweepACQData_en,
  input  logic                 UsbDataFifoFull
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [3:0] {
    IDLE, LOAD_SC, WAIT_CFG, ACQ_RUN, ACQ_STOP,
    OUT_HDR, OUT_DAC, OUT_CNT, NEXT, DONE
  } state_t;

  state_t               state, state_n;
  logic                 start_d;
  logic [DAC_WIDTH-1:0] dac_start, dac_start_n;
  logic [DAC_WIDTH-1:0] dac_end, dac_end_n;
  logic [CNT_W-1:0]     max_pkg, max_pkg_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DAC_WIDTH-1:0] out_dac, out_dac_n;
  logic [WORD_W-1:0]    data, data_n;
  logic                 load_q, acq_q, frc_q, done_q;
  logic                 sweep_rise;
  logic                 wr_en_c;
  logic                 unused_par;

  // Acquisition payload is not part of the record; only its strobe is counted.
  assign unused_par = ^ParallelData;

  assign sweep_rise = SweepStart & ~start_d;

  // A FIFO write must never coincide with full, so the strobe is gated by the
  // live full flag; the word itself is registered and stable while stalled.
  assign wr_en_c = ((state == OUT_HDR) || (state == OUT_DAC) || (state == OUT_CNT))
                   && !UsbDataFifoFull;

  assign SingleACQStart        = acq_q;
  assign ForceMicrorocAcqReset = frc_q;
  assign ACQDone               = done_q;
  assign LoadSCParameter       = load_q;
  assign OutDAC0               = out_dac;
  assign SweepACQData          = data;
  assign SweepACQData_en       = wr_en_c;

  // State register, latched sweep parameters and Moore outputs of the next state.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state     <= IDLE;
      start_d   <= 1'b0;
      dac_start <= '0;
      dac_end   <= '0;
      max_pkg   <= '0;
      cnt       <= '0;
      out_dac   <= '0;
      data      <= '0;
      load_q    <= 1'b0;
      acq_q     <= 1'b0;
      frc_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      start_d   <= SweepStart;
      dac_start <= dac_start_n;
      dac_end   <= dac_end_n;
      max_pkg   <= max_pkg_n;
      cnt       <= cnt_n;
      out_dac   <= out_dac_n;
      data      <= data_n;
      load_q    <= (state_n == LOAD_SC);
      acq_q     <= (state_n == ACQ_RUN);
      frc_q     <= (state_n == ACQ_STOP);
      done_q    <= (state_n == DONE);
    end
  end

  // Next-state, parameter latching, package counting and record word selection.
  always_comb begin
    state_n     = state;
    dac_start_n = dac_start;
    dac_end_n   = dac_end;
    max_pkg_n   = max_pkg;
    cnt_n       = cnt;
    out_dac_n   = out_dac;
    data_n      = data;

    case (state)
      IDLE: begin
        if (sweep_rise) begin
          dac_start_n = StartDAC0;
          dac_end_n   = EndDAC0;
          max_pkg_n   = MaxPackageNumber;
          out_dac_n   = StartDAC0;
          state_n     = LOAD_SC;
        end
      end
      LOAD_SC: state_n = WAIT_CFG;
      WAIT_CFG: begin
        if (MicrorocConfigDone) begin
          cnt_n   = '0;
          state_n = ACQ_RUN;
        end
      end
      ACQ_RUN: begin
        // Leave in the same cycle the limit is hit so no extra package counts.
        if (cnt == max_pkg) begin
          state_n = ACQ_STOP;
        end else if (ParallelData_en) begin
          cnt_n = CNT_W'(cnt + 1'b1);
          if (CNT_W'(cnt + 1'b1) == max_pkg) state_n = ACQ_STOP;
        end
      end
`ifdef SWEEP_ACQ_HEADER_EN
      ACQ_STOP: state_n = OUT_HDR;
`else
      ACQ_STOP: state_n = OUT_DAC;
`endif
      OUT_HDR: if (!UsbDataFifoFull) state_n = OUT_DAC;
      OUT_DAC: if (!UsbDataFifoFull) state_n = OUT_CNT;
      OUT_CNT: if (!UsbDataFifoFull) state_n = NEXT;
      NEXT: begin
        // Reversed range gives a single point; the top code never wraps.
        if ((out_dac == dac_end) || (dac_end < dac_start) || (out_dac == '1)) begin
          state_n = DONE;
        end else begin
          out_dac_n = DAC_WIDTH'(out_dac + 1'b1);
          state_n   = LOAD_SC;
        end
      end
      DONE: if (DataTransmitDone) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      OUT_HDR: data_n = HEADER_WORD;
      OUT_DAC: data_n = WORD_W'(out_dac_n);
      OUT_CNT: data_n = cnt_n;
      default: data_n = data;
    endcase
  end

endmodule

// File: tb/tb_sweep_acq_top.sv
// Scoreboard bench for sweep_acq_top: a sweep-level model queues the expected
// record words and slow-control codes; a monitor pops them as the DUT emits.
module tb_sweep_acq_top;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        SweepStart = 1'b0;
  logic        SingleACQStart, ForceMicrorocAcqReset, ACQDone;
  logic        DataTransmitDone = 1'b0;
  logic [9:0]  StartDAC0 = '0, EndDAC0 = '0;
  logic [15:0] MaxPackageNumber = '0;
  logic [15:0] ParallelData = '0;
  logic        ParallelData_en = 1'b0;
  logic [9:0]  OutDAC0;
  logic        LoadSCParameter;
  logic        MicrorocConfigDone = 1'b0;
  logic [15:0] SweepACQData;
  logic        SweepACQData_en;
  logic        UsbDataFifoFull = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_load   = 0;
  int n_frc    = 0;
  bit stress   = 1'b0;
  int full_left = 0;

  logic [15:0] exp_words[$];
  logic [9:0]  exp_dac[$];

  sweep_acq_top dut (
    .clk(clk), .reset_n(reset_n), .SweepStart(SweepStart),
    .SingleACQStart(SingleACQStart), .ForceMicrorocAcqReset(ForceMicrorocAcqReset),
    .ACQDone(ACQDone), .DataTransmitDone(DataTransmitDone),
    .StartDAC0(StartDAC0), .EndDAC0(EndDAC0), .MaxPackageNumber(MaxPackageNumber),
    .ParallelData(ParallelData), .ParallelData_en(ParallelData_en),
    .OutDAC0(OutDAC0), .LoadSCParameter(LoadSCParameter),
    .MicrorocConfigDone(MicrorocConfigDone), .SweepACQData(SweepACQData),
    .SweepACQData_en(SweepACQData_en), .UsbDataFifoFull(UsbDataFifoFull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Package strobes while acquiring, plus stray ones just after the limit.
  always @(negedge clk) begin
    ParallelData    = 16'($urandom);
    ParallelData_en = (SingleACQStart || ForceMicrorocAcqReset) ? 1'($urandom) : 1'b0;
  end

  // FIFO-full bursts of four cycles when stress is enabled.
  always @(negedge clk) begin
    if (full_left > 0) begin
      UsbDataFifoFull = 1'b1;
      full_left--;
    end else if (stress && ($urandom_range(0, 4) == 0)) begin
      UsbDataFifoFull = 1'b1;
      full_left = 3;
    end else begin
      UsbDataFifoFull = 1'b0;
    end
  end

  // Slow-control responder: config done a few cycles after each load request.
  initial forever begin
    @(negedge clk);
    MicrorocConfigDone = 1'b0;
    if (LoadSCParameter) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      MicrorocConfigDone = 1'b1;
    end
  end

  // Monitor: compares every FIFO write and every slow-control load.
  initial forever begin
    logic [15:0] w;
    logic [9:0]  d;
    @(negedge clk);
    #2;
    if (SweepACQData_en) begin
      chk("write_while_full", 32'(UsbDataFifoFull), 32'd0);
      if (exp_words.size() == 0) begin
        chk("unexpected_word", 32'(SweepACQData), 32'hFFFF_FFFF);
      end else begin
        w = exp_words.pop_front();
        chk("record_word", 32'(SweepACQData), 32'(w));
      end
    end
    if (LoadSCParameter) begin
      n_load++;
      if (exp_dac.size() == 0) begin
        chk("unexpected_load", 32'(OutDAC0), 32'hFFFF_FFFF);
      end else begin
        d = exp_dac.pop_front();
        chk("load_dac_code", 32'(OutDAC0), 32'(d));
      end
    end
    if (ForceMicrorocAcqReset) n_frc++;
  end

  // Reference model: one record per code from start to end (one if reversed).
  task automatic model_sweep(input int s, input int e, input int m, output int recs);
    int d;
    bit last;
    recs = 0;
    d = s;
    do begin
`ifdef SWEEP_ACQ_HEADER_EN
      exp_words.push_back(16'h5A5A);
`endif
      exp_words.push_back(16'(d));
      exp_words.push_back(16'(m));
      exp_dac.push_back(10'(d));
      recs++;
      last = (d == e) || (e < s);
      d++;
    end while (!last);
  endtask

  task automatic run_sweep(input int s, input int e, input int m);
    int recs;
    int cyc;
    n_load = 0;
    n_frc  = 0;
    model_sweep(s, e, m, recs);
    StartDAC0 = 10'(s);
    EndDAC0 = 10'(e);
    MaxPackageNumber = 16'(m);
    @(negedge clk) SweepStart = 1'b1;
    @(negedge clk) SweepStart = 1'b0;
    // Inputs change after the start edge; the sweep must use the latched values.
    StartDAC0 = 10'($urandom);
    EndDAC0 = 10'($urandom);
    MaxPackageNumber = 16'($urandom);
    cyc = 0;
    while (!ACQDone && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20) SweepStart = 1'b1;
      if (cyc == 21) SweepStart = 1'b0;
    end
    SweepStart = 1'b0;
    chk("acq_done_reached", 32'(ACQDone), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("acq_done_held", 32'(ACQDone), 32'd1);
    chk("words_left", 32'(exp_words.size()), 32'd0);
    chk("load_pulses", 32'(n_load), 32'(recs));
    chk("acq_reset_pulses", 32'(n_frc), 32'(recs));
    @(negedge clk) DataTransmitDone = 1'b1;
    @(negedge clk) DataTransmitDone = 1'b0;
    #1;
    chk("acq_done_cleared", 32'(ACQDone), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {22'd0, SingleACQStart, ForceMicrorocAcqReset, ACQDone,
               LoadSCParameter, SweepACQData_en, 5'd0}, 32'd0);
    chk({name, "_dac"}, 32'(OutDAC0), 32'd0);
    chk({name, "_data"}, 32'(SweepACQData), 32'd0);
  endtask

  initial begin
    int s, e, m, cyc;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset_outputs");
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("idle_outputs");

    run_sweep(475, 525, 10);
    stress = 1'b1;
    run_sweep(475, 525, 10);
    run_sweep(1023, 1023, 3);
    run_sweep(10, 5, 4);
    run_sweep(3, 6, 0);
    for (int i = 0; i < 4; i++) begin
      s = $urandom_range(1, 1023);
      if ($urandom_range(0, 3) == 0) e = $urandom_range(0, s - 1);
      else e = (s + $urandom_range(0, 4) > 1023) ? 1023 : s + $urandom_range(0, 4);
      m = $urandom_range(0, 6);
      stress = 1'($urandom);
      run_sweep(s, e, m);
    end

    // Reset during acquisition aborts the sweep.
    stress = 1'b0;
    exp_dac.push_back(10'd100);
    StartDAC0 = 10'd100;
    EndDAC0 = 10'd110;
    MaxPackageNumber = 16'd20;
    @(negedge clk) SweepStart = 1'b1;
    @(negedge clk) SweepStart = 1'b0;
    cyc = 0;
    while (!SingleACQStart && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("acq_run_reached", 32'(SingleACQStart), 32'd1);
    reset_n = 1'b1;
    #1;
    check_outputs_zero("mid_run_reset");
    exp_dac.delete();
    exp_words.delete();
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    n_load = 0;
    repeat (30) @(negedge clk);
    chk("no_load_after_abort", 32'(n_load), 32'd0);
    run_sweep(100, 102, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sweep_acq_top.md
SWEEP_ACQ_TOP -- requirements
Module: sweep_acq_top

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- HEADER_WORD, 16'h5A5A, marker word opening each per-DAC record.
- DAC_WIDTH, 10, width of the DAC0 code.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock, all logic on its rising edge.
- reset_n, in, 1, reset, asynchronous, active-high.
- SweepStart, in, 1, request to begin a sweep.
- SingleACQStart, out, 1, level-high while one DAC point is being acquired.
- ForceMicrorocAcqReset, out, 1, one-cycle pulse ending each point's acquisition.
- ACQDone, out, 1, sweep complete.
- DataTransmitDone, in, 1, host acknowledge of ACQDone.
- StartDAC0, in, 10, first DAC0 code.
- EndDAC0, in, 10, last DAC0 code.
- MaxPackageNumber, in, 16, packages to collect per DAC point.
- ParallelData, in, 16, acquisition data; unused, reserved.
- ParallelData_en, in, 1, one pulse per received package.
- OutDAC0, out, 10, DAC0 code for slow control.
- LoadSCParameter, out, 1, one-cycle pulse requesting slow-control load.
- MicrorocConfigDone, in, 1, slow-control load finished.
- SweepACQData, out, 16, record word.
- SweepACQData_en, out, 1, one-cycle write strobe for SweepACQData.
- UsbDataFifoFull, in, 1, downstream FIFO full; no write while high.

Function
REQ-003 FSM states SHALL be: IDLE, LOAD_SC, WAIT_CFG, ACQ_RUN, ACQ_STOP, OUT_HDR, OUT_DAC, OUT_CNT, NEXT, DONE.
REQ-004 IDLE SHALL detect the SweepStart rising edge, then latch StartDAC0, EndDAC0 and MaxPackageNumber, set OutDAC0=StartDAC0, and go to LOAD_SC. SweepStart SHALL be ignored outside IDLE.
REQ-005 LOAD_SC SHALL pulse LoadSCParameter for exactly one cycle, then go to WAIT_CFG. WAIT_CFG SHALL hold until MicrorocConfigDone=1, with no timeout.
REQ-006 ACQ_RUN SHALL hold SingleACQStart=1 and clear a 16-bit package counter on entry. Each ParallelData_en cycle SHALL increment the counter. The state SHALL exit to ACQ_STOP in the cycle the counter reaches the latched MaxPackageNumber. MaxPackageNumber=0 SHALL exit immediately with count 0.
REQ-007 ACQ_STOP SHALL drive SingleACQStart=0 and pulse ForceMicrorocAcqReset for one cycle. ParallelData_en pulses after the limit SHALL NOT be counted.
REQ-008 Record emission order SHALL be HEADER_WORD, {6'b0,OutDAC0}, package count. Each word SHALL be written with one SweepACQData_en pulse only in a cycle where UsbDataFifoFull=0. While the FIFO is full, the FSM SHALL stall with SweepACQData held and the enable low, and no word SHALL be lost or duplicated.
REQ-009 NEXT: if OutDAC0 equals the latched End, or End < Start, the FSM SHALL go to DONE. Otherwise OutDAC0 SHALL increment by 1 and the FSM SHALL go to LOAD_SC. A code of 1023 SHALL never wrap.
REQ-010 DONE SHALL hold ACQDone=1 until DataTransmitDone=1, then go to IDLE with ACQDone=0 in the next cycle.
REQ-011 The total SHALL be (End-Start+1) records per sweep, or 1 record if End < Start.

Reset
REQ-012 While reset_n is asserted, the FSM SHALL be in IDLE and all outputs SHALL be 0 (OutDAC0=0, SweepACQData=0). Counters and latches SHALL be cleared.
REQ-013 Reset mid-sweep SHALL abort immediately. No further LoadSCParameter or SweepACQData_en SHALL occur until a new SweepStart edge.

Configuration
REQ-014 With macro SWEEP_ACQ_HEADER_EN defined, each record SHALL be 3 words as in REQ-008.
REQ-015 Without SWEEP_ACQ_HEADER_EN, OUT_HDR SHALL be skipped and each record SHALL be 2 words (DAC, count). All other behaviour SHALL be unchanged.

Verification
REQ-016 Start=475, End=525, Max=10, ten ParallelData_en pulses per point -> 51 LoadSCParameter pulses, 51 ForceMicrorocAcqReset pulses, and 153 words in order 5A5A/01DB/000A ... 5A5A/020D/000A, then ACQDone.
REQ-017 UsbDataFifoFull high for 4 cycles during record output -> no strobe while full; word sequence identical to the unstalled run.
REQ-018 Start=End=1023, Max=3 -> single record 5A5A/03FF/0003 and no wrap to 0.
REQ-019 Start=10, End=5 -> one record at DAC 10, then ACQDone. Max=0 -> count word 0000 with no ParallelData_en needed.
REQ-020 reset_n asserted during ACQ_RUN -> all outputs 0 immediately. SweepStart pulsed again after reset -> sweep restarts from Start.
REQ-021 ACQDone held high until DataTransmitDone pulse -> FSM returns to IDLE the next cycle. A second SweepStart while busy SHALL be ignored.
